// File: rtl/dmem_router.sv
// Data-side OBI router: splits core data requests between RAM, a small MMIO test-control window and an
// unmapped sink, and returns responses in order. Define DMEM_ROUTER_TAG_EN to route the tag memory alongside RAM.
`timescale 1ns/1ps

module dmem_router #(
   parameter logic [31:0] RAM_BASE       = 32'h0000_1000,
   parameter int unsigned RAM_SIZE       = 8192,
   parameter logic [31:0] MMIO_BASE      = 32'h2000_0000,
   parameter int unsigned OUTSTANDING    = 2,
   parameter logic [31:0] UNMAPPED_RDATA = 32'hBADC_0FFE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        core_req,
   output logic        core_gnt,
   output logic        core_rvalid,
   input  logic [31:0] core_addr,
   input  logic        core_we,
   input  logic [3:0]  core_be,
   input  logic [31:0] core_wdata,
   output logic [31:0] core_rdata,
   input  logic        core_we_tag,
   input  logic [3:0]  core_wdata_tag,
   output logic [3:0]  core_rdata_tag,
   output logic        ram_req,
   input  logic        ram_gnt,
   input  logic        ram_rvalid,
   output logic [31:0] ram_addr,
   output logic        ram_we,
   output logic [3:0]  ram_be,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata,
   output logic        tag_req,
   input  logic        tag_gnt,
   input  logic        tag_rvalid,
   output logic        tag_we,
   output logic [3:0]  tag_wdata,
   input  logic [3:0]  tag_rdata,
   output logic        con_valid,
   output logic [7:0]  con_char,
   output logic        test_done,
   output logic [31:0] test_code,
   output logic        unmapped_err,
   output logic        order_err
);

   localparam int unsigned PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
   localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUTSTANDING - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUTSTANDING);

   logic [31:0]      ram_off;
   logic             hit_ram;
   logic             hit_mmio;
   logic             full;
   logic             head_vld;
   logic             head_ram;
   logic             mem_gnt;
   logic             ram_done;
   logic             local_gnt;
   logic             mmio_gnt;
   logic             push;
   logic             pop;
   logic [31:0]      local_rdata;
   logic [31:0]      ram_rdata_eff;
   logic [3:0]       tag_rdata_eff;
   logic [CNT_W-1:0] count;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             fifo_ram  [OUTSTANDING];
   logic [31:0]      fifo_data [OUTSTANDING];
   logic [31:0]      cycle_cnt;

   // Unsigned subtract makes addresses below RAM_BASE wrap to huge offsets and miss.
   assign ram_off  = core_addr - RAM_BASE;
   assign hit_ram  = ram_off < 32'(RAM_SIZE);
   assign hit_mmio = core_addr[31:4] == MMIO_BASE[31:4];
   assign full     = count == FULL_CNT;
   assign head_vld = count != '0;
   assign head_ram = fifo_ram[rd_ptr];

   always_comb begin
      ram_req  = 1'b0;
      core_gnt = 1'b0;
      if (core_req && !full) begin
         if (hit_ram) begin
            ram_req  = 1'b1;
            core_gnt = mem_gnt;
         end else begin
            core_gnt = 1'b1;
         end
      end
   end

   assign ram_addr  = ram_req ? ram_off    : '0;
   assign ram_we    = ram_req & core_we;
   assign ram_be    = ram_req ? core_be    : '0;
   assign ram_wdata = ram_req ? core_wdata : '0;

   assign push      = core_gnt;
   assign local_gnt = core_gnt & ~hit_ram;
   assign mmio_gnt  = local_gnt & hit_mmio;

`ifdef DMEM_ROUTER_TAG_EN
   logic        ram_seen;
   logic        tag_seen;
   logic [31:0] ram_skid;
   logic [3:0]  tag_skid;

   assign mem_gnt   = ram_gnt & tag_gnt;
   assign tag_req   = ram_req;
   assign tag_we    = ram_req & core_we_tag;
   assign tag_wdata = ram_req ? core_wdata_tag : '0;

   // Either response may come first; the early one waits in its skid register.
   assign ram_done      = head_vld & head_ram & (ram_seen | ram_rvalid) & (tag_seen | tag_rvalid);
   assign ram_rdata_eff = ram_seen ? ram_skid : ram_rdata;
   assign tag_rdata_eff = tag_seen ? tag_skid : tag_rdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         ram_seen <= 1'b0;
         tag_seen <= 1'b0;
         ram_skid <= '0;
         tag_skid <= '0;
      end else if (ram_done) begin
         ram_seen <= 1'b0;
         tag_seen <= 1'b0;
      end else if (head_vld && head_ram) begin
         if (ram_rvalid && !ram_seen) begin
            ram_seen <= 1'b1;
            ram_skid <= ram_rdata;
         end
         if (tag_rvalid && !tag_seen) begin
            tag_seen <= 1'b1;
            tag_skid <= tag_rdata;
         end
      end
   end
`else
   logic unused_tag;

   assign unused_tag    = ^{tag_gnt, tag_rvalid, tag_rdata, core_we_tag, core_wdata_tag};
   assign mem_gnt       = ram_gnt;
   assign tag_req       = 1'b0;
   assign tag_we        = 1'b0;
   assign tag_wdata     = '0;
   assign ram_done      = head_vld & head_ram & ram_rvalid;
   assign ram_rdata_eff = ram_rdata;
   assign tag_rdata_eff = '0;
`endif

   assign pop            = head_vld & (head_ram ? ram_done : 1'b1);
   assign core_rvalid    = pop;
   assign core_rdata     = !pop ? '0 : (head_ram ? ram_rdata_eff : fifo_data[rd_ptr]);
   assign core_rdata_tag = (pop && head_ram) ? tag_rdata_eff : '0;

   // Local read data is captured at grant time so a later response sees the value of that cycle.
   always_comb begin
      local_rdata = '0;
      if (!core_we) begin
         if (!hit_mmio) begin
            local_rdata = UNMAPPED_RDATA;
         end else begin
            case (core_addr[3:2])
               2'd1:    local_rdata = test_code;
               2'd2:    local_rdata = cycle_cnt;
               default: local_rdata = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (push) begin
            fifo_ram[wr_ptr]  <= hit_ram;
            fifo_data[wr_ptr] <= local_rdata;
            wr_ptr            <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt    <= '0;
         con_valid    <= 1'b0;
         con_char     <= '0;
         test_done    <= 1'b0;
         test_code    <= '0;
         unmapped_err <= 1'b0;
         order_err    <= 1'b0;
      end else begin
         cycle_cnt <= cycle_cnt + 1'b1;
         con_valid <= 1'b0;
         if (mmio_gnt && core_we) begin
            case (core_addr[3:2])
               2'd0: begin
                  con_valid <= 1'b1;
                  con_char  <= core_wdata[7:0];
               end
               2'd1: begin
                  test_done <= 1'b1;
                  test_code <= core_wdata;
               end
               default: ;
            endcase
         end
         if (local_gnt && !hit_mmio) begin
            unmapped_err <= 1'b1;
         end
         // An empty FIFO swallows stray responses, e.g. ones still in flight across a reset.
         if (ram_rvalid && head_vld && !head_ram) begin
            order_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dmem_router.sv
// Directed bench for dmem_router: table of single transactions plus hand-written sequences
// for console bursts, FIFO-full stalls, cycle counter spacing, order errors and mid-transaction reset.
`timescale 1ns/1ps

module tb_dmem_router;

   logic        clk = 1'b0;
   logic        rst;
   logic        core_req, core_gnt, core_rvalid, core_we, core_we_tag;
   logic [31:0] core_addr, core_wdata, core_rdata;
   logic [3:0]  core_be, core_wdata_tag, core_rdata_tag;
   logic        ram_req, ram_gnt, ram_rvalid, ram_we;
   logic [31:0] ram_addr, ram_wdata, ram_rdata;
   logic [3:0]  ram_be;
   logic        tag_req, tag_gnt, tag_rvalid, tag_we;
   logic [3:0]  tag_wdata, tag_rdata;
   logic        con_valid, test_done, unmapped_err, order_err;
   logic [7:0]  con_char;
   logic [31:0] test_code;

   always #5 clk = ~clk;

   assign tag_gnt    = 1'b1;
   assign tag_rvalid = ram_rvalid;
   assign tag_rdata  = 4'h0;

   dmem_router dut (
      .clk(clk), .rst(rst),
      .core_req(core_req), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
      .core_addr(core_addr), .core_we(core_we), .core_be(core_be),
      .core_wdata(core_wdata), .core_rdata(core_rdata),
      .core_we_tag(core_we_tag), .core_wdata_tag(core_wdata_tag), .core_rdata_tag(core_rdata_tag),
      .ram_req(ram_req), .ram_gnt(ram_gnt), .ram_rvalid(ram_rvalid), .ram_addr(ram_addr),
      .ram_we(ram_we), .ram_be(ram_be), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .tag_req(tag_req), .tag_gnt(tag_gnt), .tag_rvalid(tag_rvalid), .tag_we(tag_we),
      .tag_wdata(tag_wdata), .tag_rdata(tag_rdata),
      .con_valid(con_valid), .con_char(con_char), .test_done(test_done), .test_code(test_code),
      .unmapped_err(unmapped_err), .order_err(order_err)
   );

   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // RAM model: samples the handshake just before the edge, answers after ram_lat cycles.
   typedef struct { logic [31:0] data; int due; } rsp_t;
   rsp_t        rq[$];
   logic [31:0] mem [0:2047];
   int          ram_lat = 1;
   int          cyc = 0;
   int          ram_req_cycles = 0;
   int          ram_rv_cnt = 0;
   logic [31:0] last_off = '0;

   initial begin
      logic        hs, we_s;
      logic [31:0] a_s, d_s;
      logic [3:0]  be_s;
      ram_rvalid = 1'b0;
      ram_rdata  = '0;
      for (int i = 0; i < 2048; i++) mem[i] = '0;
      forever begin
         @(negedge clk);
         #4;
         hs   = ram_req & ram_gnt;
         we_s = ram_we;
         a_s  = ram_addr;
         d_s  = ram_wdata;
         be_s = ram_be;
         if (ram_req) ram_req_cycles++;
         @(posedge clk);
         #1;
         cyc++;
         ram_rvalid = 1'b0;
         ram_rdata  = '0;
         if (rq.size() > 0 && rq[0].due <= cyc) begin
            ram_rvalid = 1'b1;
            ram_rdata  = rq[0].data;
            void'(rq.pop_front());
            ram_rv_cnt++;
         end
         if (hs) begin
            last_off = a_s;
            if (we_s) begin
               for (int b = 0; b < 4; b++)
                  if (be_s[b]) mem[a_s[12:2]][b*8 +: 8] = d_s[b*8 +: 8];
               rq.push_back('{32'h0, cyc + ram_lat});
            end else begin
               rq.push_back('{mem[a_s[12:2]], cyc + ram_lat});
            end
         end
      end
   end

   int          con_cnt = 0;
   logic [7:0]  con_last = '0;
   int          con_cyc_q[$];
   logic [7:0]  con_chr_q[$];
   logic [31:0] rsp_q[$];

   always @(negedge clk) begin
      if (con_valid) begin
         con_cnt++;
         con_last = con_char;
         con_cyc_q.push_back(cyc);
         con_chr_q.push_back(con_char);
      end
      if (core_rvalid) rsp_q.push_back(core_rdata);
   end

   task automatic do_txn(input logic [31:0] a, input logic w, input logic [31:0] d,
                         output logic [31:0] rd, output logic ok);
      logic got;
      ok  = 1'b0;
      rd  = '0;
      got = 1'b0;
      @(negedge clk);
      core_req   = 1'b1;
      core_addr  = a;
      core_we    = w;
      core_wdata = d;
      core_be    = 4'hF;
      for (int n = 0; n < 50; n++) begin
         #1;
         if (core_gnt) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      core_req = 1'b0;
      core_we  = 1'b0;
      if (!got) return;
      for (int n = 0; n < 50; n++) begin
         #1;
         if (core_rvalid) begin
            rd = core_rdata;
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        ram;
      logic [31:0] off;
      logic        unm;
   } vec_t;

   vec_t vt[14];

   initial begin
      logic [31:0] rd;
      logic        ok;
      int          rc0, rv0;

      vt[0]  = '{32'h0000_1010, 1'b1, 32'h1234_5678, 32'h0,         1'b1, 32'h010,  1'b0};
      vt[1]  = '{32'h0000_1010, 1'b0, 32'h0,         32'h1234_5678, 1'b1, 32'h010,  1'b0};
      vt[2]  = '{32'h0000_2FFC, 1'b1, 32'hCAFE_F00D, 32'h0,         1'b1, 32'h1FFC, 1'b0};
      vt[3]  = '{32'h0000_2FFC, 1'b0, 32'h0,         32'hCAFE_F00D, 1'b1, 32'h1FFC, 1'b0};
      vt[4]  = '{32'h0000_1000, 1'b0, 32'h0,         32'h0,         1'b1, 32'h000,  1'b0};
      vt[5]  = '{32'h2000_0000, 1'b1, 32'h0000_0041, 32'h0,         1'b0, 32'h0,    1'b0};
      vt[6]  = '{32'h2000_0000, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0,    1'b0};
      vt[7]  = '{32'h2000_000C, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0,    1'b0};
      vt[8]  = '{32'h2000_0008, 1'b1, 32'h0000_0055, 32'h0,         1'b0, 32'h0,    1'b0};
      vt[9]  = '{32'h0000_0F00, 1'b0, 32'h0,         32'hBADC_0FFE, 1'b0, 32'h0,    1'b1};
      vt[10] = '{32'h3000_0000, 1'b0, 32'h0,         32'hBADC_0FFE, 1'b0, 32'h0,    1'b1};
      vt[11] = '{32'h0000_3000, 1'b0, 32'h0,         32'hBADC_0FFE, 1'b0, 32'h0,    1'b1};
      vt[12] = '{32'h2000_0010, 1'b0, 32'h0,         32'hBADC_0FFE, 1'b0, 32'h0,    1'b1};
      vt[13] = '{32'h0000_0FFC, 1'b1, 32'h0000_0077, 32'h0,         1'b0, 32'h0,    1'b1};

      rst = 1'b1;
      core_req = 1'b0; core_addr = '0; core_we = 1'b0; core_be = '0; core_wdata = '0;
      core_we_tag = 1'b0; core_wdata_tag = '0; ram_gnt = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_ctrl", {core_gnt, core_rvalid, ram_req, tag_req, tag_we, con_valid,
                       test_done, unmapped_err, order_err}, 32'h0);
      chk("rst_data", core_rdata | test_code | ram_addr | {24'h0, con_char}, 32'h0);
      rst = 1'b0;

      for (int i = 0; i < 14; i++) begin
         rc0 = ram_req_cycles;
         do_txn(vt[i].addr, vt[i].we, vt[i].wdata, rd, ok);
         chk($sformatf("v%0d_done", i), ok, 1'b1);
         chk($sformatf("v%0d_rdata", i), rd, vt[i].rdata);
         chk($sformatf("v%0d_ram_req", i), ram_req_cycles - rc0, vt[i].ram);
         if (vt[i].ram) chk($sformatf("v%0d_ram_addr", i), last_off, vt[i].off);
         chk($sformatf("v%0d_unmapped_err", i), unmapped_err, vt[i].unm);
      end
      chk("order_err_clean", order_err, 1'b0);
      chk("con_pulses", con_cnt, 1);
      chk("con_char", con_last, 8'h41);

      // End of test flag holds through idle time.
      do_txn(32'h2000_0004, 1'b1, 32'h0000_0001, rd, ok);
      chk("exit_done", test_done, 1'b1);
      chk("exit_code", test_code, 32'h1);
      repeat (100) @(negedge clk);
      chk("exit_done_hold", test_done, 1'b1);
      chk("exit_code_hold", test_code, 32'h1);
      do_txn(32'h2000_0004, 1'b0, 32'h0, rd, ok);
      chk("exit_readback", rd, 32'h1);

      // Back-to-back console writes.
      con_cyc_q.delete();
      con_chr_q.delete();
      @(negedge clk);
      core_req = 1'b1; core_we = 1'b1; core_addr = 32'h2000_0000; core_wdata = 32'h48;
      #1 chk("con_b2b_gnt0", core_gnt, 1'b1);
      @(negedge clk);
      core_wdata = 32'h49;
      #1 chk("con_b2b_gnt1", core_gnt, 1'b1);
      @(negedge clk);
      core_req = 1'b0; core_we = 1'b0;
      repeat (3) @(negedge clk);
      chk("con_b2b_count", con_chr_q.size(), 2);
      if (con_chr_q.size() >= 2) begin
         chk("con_b2b_char0", con_chr_q[0], 8'h48);
         chk("con_b2b_char1", con_chr_q[1], 8'h49);
         chk("con_b2b_spacing", con_cyc_q[1] - con_cyc_q[0], 1);
      end

      // Two CYCLE reads granted 10 cycles apart.
      rsp_q.delete();
      @(negedge clk);
      core_req = 1'b1; core_addr = 32'h2000_0008;
      #1 chk("cyc_gnt0", core_gnt, 1'b1);
      @(negedge clk);
      core_req = 1'b0;
      repeat (9) @(negedge clk);
      core_req = 1'b1;
      #1 chk("cyc_gnt1", core_gnt, 1'b1);
      @(negedge clk);
      core_req = 1'b0;
      for (int n = 0; n < 20 && rsp_q.size() < 2; n++) @(negedge clk);
      chk("cyc_rsp_count", rsp_q.size(), 2);
      if (rsp_q.size() >= 2) chk("cyc_delta", rsp_q[1] - rsp_q[0], 32'd10);

      // Stalled RAM read followed by an MMIO read fills the FIFO.
      ram_lat = 6;
      rsp_q.delete();
      @(negedge clk);
      core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0000_1010;
      #1 chk("stall_ram_gnt", core_gnt, 1'b1);
      @(negedge clk);
      core_addr = 32'h2000_0008;
      #1 chk("stall_mmio_gnt", core_gnt, 1'b1);
      @(negedge clk);
      core_addr = 32'h0000_1010;
      #1 chk("full_gnt", core_gnt, 1'b0);
      chk("full_ram_req", ram_req, 1'b0);
      @(negedge clk);
      core_req = 1'b0;
      for (int n = 0; n < 30 && rsp_q.size() < 2; n++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("stall_rsp_count", rsp_q.size(), 2);
      if (rsp_q.size() >= 1) chk("stall_ram_first", rsp_q[0], 32'h1234_5678);
      chk("stall_order_err", order_err, 1'b0);
      ram_lat = 1;

      // A stray RAM response while a local entry is at the head.
      @(negedge clk);
      core_req = 1'b1; core_addr = 32'h2000_000C;
      @(negedge clk);
      core_req = 1'b0;
      ram_rvalid = 1'b1;
      @(negedge clk);
      chk("stray_order_err", order_err, 1'b1);

      // Reset with one RAM read in flight; its late response must vanish.
      ram_lat = 3;
      @(negedge clk);
      core_req = 1'b1; core_addr = 32'h0000_1010;
      #1 chk("rst_txn_gnt", core_gnt, 1'b1);
      @(negedge clk);
      core_req = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst2_ctrl", {core_gnt, core_rvalid, ram_req, tag_req, con_valid,
                        test_done, unmapped_err, order_err}, 32'h0);
      chk("rst2_data", core_rdata | test_code | ram_addr | {24'h0, con_char}, 32'h0);
      rsp_q.delete();
      rv0 = ram_rv_cnt;
      repeat (6) @(negedge clk);
      chk("late_rvalid_seen", ram_rv_cnt - rv0, 1);
      chk("late_core_rvalid", rsp_q.size(), 0);
      chk("late_order_err", order_err, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
